// File: rtl/fast_pkg.sv
// Shared constants and types for the FAST corner-detection front end.
// Window geometry is fixed at 7x7; six line buffers supply the six
// rows above the current one.
package fast_pkg;

  localparam int FAST_WIN      = 7;
  localparam int FAST_LB_LINES = 6;
  localparam int PIX_W         = 8;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [FAST_WIN-1:0][FAST_WIN-1:0] window_t;

endpackage

// File: rtl/fast_line_buffer.sv
// One raster line of storage, addressed by column. The read port is
// combinational so the old contents of a column can be forwarded to the
// next line buffer in the same cycle that the column is overwritten.
module fast_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    din_i,
  output logic [DATA_WIDTH-1:0]    dout_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the new pixel for this column; the read below still sees the old one.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= din_i;
  end

  assign dout_o = mem[addr_i];

endmodule

// File: rtl/fast_window_gen.sv
// Raster pixel stream -> 7x7 neighbourhood generator for the FAST detector.
// Six chained line buffers hold the previous six rows; a 7x7 register
// array shifts left by one column on every accepted pixel.
// Optional build macro FAST_WIN_COORD_EN adds win_x/win_y centre
// coordinate outputs registered alongside the window.
module fast_window_gen
  import fast_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             pix_valid,
  input  logic [DATA_WIDTH-1:0]                            pix_data,
  input  logic                                             sof,
  output logic                                             window_valid,
  output logic [FAST_WIN-1:0][FAST_WIN-1:0][DATA_WIDTH-1:0] window,
`ifdef FAST_WIN_COORD_EN
  output logic [$clog2(IMG_WIDTH)-1:0]                     win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]                    win_y,
`endif
  output logic                                             frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          vld_q, vld_d;
  logic          fdone_q, fdone_d;
  logic [FAST_WIN-1:0][FAST_WIN-1:0][DATA_WIDTH-1:0] window_q, window_d;
  logic [DATA_WIDTH-1:0] lb_rd [FAST_LB_LINES];
  logic [DATA_WIDTH-1:0] lb_wr [FAST_LB_LINES];
  logic                  full_nbhd;

  // An accepted sof pixel is frame pixel (0,0) whatever the counters say.
  always_comb begin
    col_eff = col_q;
    row_eff = row_q;
    if (pix_valid && sof) begin
      col_eff = '0;
      row_eff = '0;
    end
  end

  assign full_nbhd = (col_eff >= CW'(FAST_WIN-1)) && (row_eff >= RW'(FAST_WIN-1));

  // Raster counters, window-valid and end-of-frame pulses.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    vld_d   = 1'b0;
    fdone_d = 1'b0;
    if (pix_valid) begin
      vld_d = full_nbhd;
      if (col_eff == CW'(IMG_WIDTH-1)) begin
        col_d = '0;
        if (row_eff == RW'(IMG_HEIGHT-1)) begin
          row_d   = '0;
          fdone_d = 1'b1;
        end else begin
          row_d = row_eff + RW'(1);
        end
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  // Line buffer k is fed by line buffer k-1, so lb[k] holds row-1-k.
  for (genvar k = 0; k < FAST_LB_LINES; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wr[k] = pix_data;
    end else begin : g_chain
      assign lb_wr[k] = lb_rd[k-1];
    end
    fast_line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH)
    ) u_lb (
      .clk    (clk),
      .we_i   (pix_valid),
      .addr_i (col_eff),
      .din_i  (lb_wr[k]),
      .dout_o (lb_rd[k])
    );
  end

  // Shift the window left one column and load the new right-hand column.
  always_comb begin
    window_d = window_q;
    if (pix_valid) begin
      for (int r = 0; r < FAST_WIN; r++) begin
        for (int c = 0; c < FAST_WIN-1; c++) begin
          window_d[r][c] = window_q[r][c+1];
        end
      end
      for (int k = 0; k < FAST_LB_LINES; k++) begin
        window_d[FAST_LB_LINES-1-k][FAST_WIN-1] = lb_rd[k];
      end
      window_d[FAST_WIN-1][FAST_WIN-1] = pix_data;
    end
  end

  // State register: counters, pulses and the window array.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      vld_q    <= 1'b0;
      fdone_q  <= 1'b0;
      window_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      vld_q    <= vld_d;
      fdone_q  <= fdone_d;
      window_q <= window_d;
    end
  end

  assign window_valid = vld_q;
  assign frame_done   = fdone_q;
  assign window       = window_q;

`ifdef FAST_WIN_COORD_EN
  logic [CW-1:0] win_x_q, win_x_d;
  logic [RW-1:0] win_y_q, win_y_d;

  // Centre coordinates follow the window only when it is a full neighbourhood.
  always_comb begin
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    if (pix_valid && full_nbhd) begin
      win_x_d = col_eff - CW'(3);
      win_y_d = row_eff - RW'(3);
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
    end
  end

  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

endmodule

// File: tb/tb_fast_window_gen.sv
// Self-checking bench for fast_window_gen on a 16x8 frame.
module tb_fast_window_gen;

  localparam int DW = 8;
  localparam int W  = 16;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst;
  logic pix_valid;
  logic [DW-1:0] pix_data;
  logic sof;
  logic window_valid;
  logic [6:0][6:0][DW-1:0] window;
  logic frame_done;
`ifdef FAST_WIN_COORD_EN
  logic [3:0] win_x;
  logic [2:0] win_y;
`endif

  fast_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .sof          (sof),
    .window_valid (window_valid),
    .window       (window),
`ifdef FAST_WIN_COORD_EN
    .win_x        (win_x),
    .win_y        (win_y),
`endif
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: image as written, raster position, expectations
  logic [DW-1:0] img [H][W];
  int m_col = 0, m_row = 0;
  bit exp_v, exp_fd;
  logic [6:0][6:0][DW-1:0] exp_w;
  int exp_x = 0, exp_y = 0;
  int obs_cnt = 0;

  // recorded observations of the plain frame, keyed by pixel position
  bit rec = 0;
  bit       tv  [H][W];
  logic [DW-1:0] t00 [H][W];
  logic [DW-1:0] t33 [H][W];
  logic [DW-1:0] t66 [H][W];

  typedef struct {
    int row; int col; bit v;
    logic [DW-1:0] w00; logic [DW-1:0] w33; logic [DW-1:0] w66;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [391:0] act, input logic [391:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push(input bit v, input bit s, input logic [DW-1:0] d);
    int ec, er;
    ec = 0; er = 0;
    pix_valid = v; sof = s; pix_data = d;
    exp_v = 0; exp_fd = 0;
    if (v) begin
      ec = s ? 0 : m_col;
      er = s ? 0 : m_row;
      img[er][ec] = d;
      exp_v  = (ec >= 6) && (er >= 6);
      exp_fd = (er == H-1) && (ec == W-1);
      if (exp_v) begin
        for (int r = 0; r < 7; r++)
          for (int c = 0; c < 7; c++)
            exp_w[r][c] = img[er-6+r][ec-6+c];
        exp_x = ec - 3;
        exp_y = er - 3;
      end
      m_col = ec + 1;
      m_row = er;
      if (m_col == W) begin
        m_col = 0;
        m_row = (er == H-1) ? 0 : er + 1;
      end
    end
    @(posedge clk); #1;
    chk("window_valid", 392'(window_valid), 392'(exp_v));
    chk("frame_done", 392'(frame_done), 392'(exp_fd));
    if (exp_v) chk("window", window, exp_w);
`ifdef FAST_WIN_COORD_EN
    chk("win_x", 392'(win_x), 392'(exp_x));
    chk("win_y", 392'(win_y), 392'(exp_y));
`endif
    if (window_valid) obs_cnt++;
    if (rec && v) begin
      tv[er][ec]  = window_valid;
      t00[er][ec] = window[0][0];
      t33[er][ec] = window[3][3];
      t66[er][ec] = window[6][6];
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1; pix_valid = 0; sof = 0; pix_data = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 0;
    m_col = 0; m_row = 0; exp_x = 0; exp_y = 0;
    chk("reset window_valid", 392'(window_valid), 392'(0));
    chk("reset frame_done", 392'(frame_done), 392'(0));
    chk("reset window", window, '0);
`ifdef FAST_WIN_COORD_EN
    chk("reset win_x", 392'(win_x), 392'(0));
    chk("reset win_y", 392'(win_y), 392'(0));
`endif
  endtask

  initial begin
    // expected window samples for pix = row*16+col; window[r][c] = pixel(row-6+r, col-6+c)
    tbl[0] = '{6, 6, 1'b1, 8'd0,  8'd51, 8'd102};
    tbl[1] = '{6, 15, 1'b1, 8'd9,  8'd60, 8'd111};
    tbl[2] = '{7, 6, 1'b1, 8'd16, 8'd67, 8'd118};
    tbl[3] = '{7, 15, 1'b1, 8'd25, 8'd76, 8'd127};
    tbl[4] = '{7, 10, 1'b1, 8'd20, 8'd71, 8'd122};
    tbl[5] = '{6, 5, 1'b0, 8'd0,  8'd0,  8'd0};
    tbl[6] = '{7, 0, 1'b0, 8'd0,  8'd0,  8'd0};
    tbl[7] = '{5, 15, 1'b0, 8'd0,  8'd0,  8'd0};

    do_reset(3);

    // plain frame, continuous valid, sof on first pixel
    rec = 1; obs_cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        push(1, (r == 0 && c == 0), DW'(r*16 + c));
    rec = 0;
    chk("frame windows continuous", 392'(obs_cnt), 392'(20));
    push(0, 0, 8'hAA);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl%0d valid", i), 392'(tv[tbl[i].row][tbl[i].col]), 392'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d w00", i), 392'(t00[tbl[i].row][tbl[i].col]), 392'(tbl[i].w00));
        chk($sformatf("tbl%0d w33", i), 392'(t33[tbl[i].row][tbl[i].col]), 392'(tbl[i].w33));
        chk($sformatf("tbl%0d w66", i), 392'(t66[tbl[i].row][tbl[i].col]), 392'(tbl[i].w66));
      end
    end

    // same frame without sof (counters wrapped), pix_valid toggling
    obs_cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        push(1, 0, DW'(r*16 + c));
        push(0, 0, 8'h55);
      end
    chk("frame windows toggled", 392'(obs_cnt), 392'(20));

    // sof restart at (3,5) mid-frame
    for (int p = 0; p < 3*16+5; p++) push(1, 0, DW'(p));
    obs_cnt = 0;
    for (int p = 0; p < W*H; p++) push(1, (p == 0), DW'(200 + p));
    chk("frame windows after sof", 392'(obs_cnt), 392'(20));

    // randomized traffic with rare sof and one mid-stream reset
    for (int i = 0; i < 700; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 249) == 0);
      if (i == 300) do_reset(1);
      push(v, s, DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
